// File: rtl/rv32_data_bus_adapter_pkg.sv
// Shared types and constants for the RV32 data-bus adapter.
package rv32_bus_pkg;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  // External bus widths.
  localparam int RV32_BUS_ADR_W = 30;
  localparam int RV32_BUS_DAT_W = 32;
  localparam int RV32_BUS_SEL_W = 4;

  // Byte selects used for every read: the whole word is fetched.
  localparam logic [RV32_BUS_SEL_W-1:0] RV32_BUS_SEL_WORD = 4'b1111;

  // Byte selects for a request: writes use the lane mask, reads the full word.
  function automatic logic [RV32_BUS_SEL_W-1:0] bus_sel_for(
    input logic                      we,
    input logic [RV32_BUS_SEL_W-1:0] mask
  );
    logic [RV32_BUS_SEL_W-1:0] sel;
    if (we) begin
      sel = mask;
    end else begin
      sel = RV32_BUS_SEL_WORD;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rv32_data_bus_adapter_if.sv
// Wishbone-style external data bus between the adapter and a bus slave.
interface rv32_data_bus_adapter_if;
  import rv32_bus_pkg::*;

  logic                      bus_cyc_out;
  logic                      bus_we_out;
  logic [RV32_BUS_SEL_W-1:0] bus_sel_out;
  logic [RV32_BUS_ADR_W-1:0] bus_adr_out;
  logic [RV32_BUS_DAT_W-1:0] bus_dat_out;
  logic [RV32_BUS_DAT_W-1:0] bus_dat_in;
  logic                      bus_ack_in;

  // Adapter side: issues the cycle, consumes ack and read data.
  modport master (
    output bus_cyc_out,
    output bus_we_out,
    output bus_sel_out,
    output bus_adr_out,
    output bus_dat_out,
    input  bus_dat_in,
    input  bus_ack_in
  );

  // Slave side: observes the cycle, answers with ack and read data.
  modport slave (
    input  bus_cyc_out,
    input  bus_we_out,
    input  bus_sel_out,
    input  bus_adr_out,
    input  bus_dat_out,
    output bus_dat_in,
    output bus_ack_in
  );

endinterface

// File: rtl/rv32_data_bus_adapter.sv
// Turns the memory stage's combinational data request into a registered
// cyc/ack bus transaction, stalling the pipeline until it completes or
// times out. Read data is held in a register the memory stage picks up
// on the edge that leaves DONE.
module rv32_data_bus_adapter
  import rv32_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      data_read_in,
  input  logic                      data_write_in,
  input  logic [RV32_BUS_SEL_W-1:0] data_write_mask_in,
  input  logic [31:0]               data_address_in,
  input  logic [RV32_BUS_DAT_W-1:0] data_write_value_in,
  output logic [RV32_BUS_DAT_W-1:0] data_read_value_out,
  output logic                      stall_out,
  output logic                      bus_error_out,
  rv32_data_bus_adapter_if.master   bus
);

  // Counter exits at TIMEOUT_CYCLES-1, so it never needs to wrap.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_t                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [RV32_BUS_DAT_W-1:0] rdata_q, rdata_d;
  logic [RV32_BUS_ADR_W-1:0] adr_q, adr_d;
  logic                      we_q, we_d;
  logic [RV32_BUS_SEL_W-1:0] sel_q, sel_d;
  logic [RV32_BUS_DAT_W-1:0] dat_q, dat_d;
  logic                      cyc_q, cyc_d;
  logic                      err_q, err_d;
  logic                      req_s;
  logic                      stall_s;

  // Write wins when both strobes are high; that case is illegal upstream.
  assign req_s = data_read_in | data_write_in;

  // Next-state, latch and stall decode for the transaction FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    err_d   = 1'b0;
    stall_s = 1'b0;
    case (state_q)
      IDLE: begin
        stall_s = req_s;
        if (req_s) begin
          state_d = BUSY;
          adr_d   = data_address_in[31:2];
          we_d    = data_write_in;
          sel_d   = bus_sel_for(data_write_in, data_write_mask_in);
          dat_d   = data_write_value_in;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (bus.bus_ack_in) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = bus.bus_dat_in;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the cycle: report the error and return zero data.
          state_d = DONE;
          rdata_d = 32'h0000_0000;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        stall_s = 1'b0;
        state_d = IDLE;
      end
      default: begin
        stall_s = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // cyc is registered from the next state so it is glitch-free on the bus.
  assign cyc_d = (state_d == BUSY);

  // State, counter, latched request and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

  assign bus.bus_cyc_out   = cyc_q;
  assign bus.bus_we_out    = we_q;
  assign bus.bus_sel_out   = sel_q;
  assign bus.bus_adr_out   = adr_q;
  assign bus.bus_dat_out   = dat_q;
  assign data_read_value_out = rdata_q;
  assign bus_error_out     = err_q;
  assign stall_out         = stall_s;

endmodule

// File: doc/rv32_data_bus_adapter.md
Name: rv32_data_bus_adapter

Overview:
- Sits directly downstream of the memory stage's data-memory port.
- Converts the memory stage's single-cycle, combinational read/write request into a registered, Wishbone-style cyc/ack transaction on an external data bus.
- Asserts stall to the hazard unit until the transaction completes, then presents the latched read data so the memory stage captures it on the first unstalled edge.
- Bounds every transaction with a timeout; a timed-out transaction reports a bus error.

Parameters:
TIMEOUT_CYCLES, 255, maximum number of cycles cyc is held without ack before the transaction is abandoned (legal range 1..65535)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
data_read_in  input  1  read request from the memory stage
data_write_in  input  1  write request from the memory stage
data_write_mask_in  input  4  byte-lane enables for writes
data_address_in  input  32  byte address
data_write_value_in  input  32  lane-aligned write data
data_read_value_out  output  32  read data returned to the memory stage
stall_out  output  1  to the hazard unit; freezes the pipeline while a transaction is outstanding
bus_error_out  output  1  one-cycle pulse when a transaction times out
bus_cyc_out  output  1  bus cycle valid
bus_we_out  output  1  bus write enable
bus_sel_out  output  4  bus byte selects
bus_adr_out  output  30  word address (byte address bits 31:2)
bus_dat_out  output  32  bus write data
bus_dat_in  input  32  bus read data; sampled only when bus_ack_in=1
bus_ack_in  input  1  transaction complete

Behaviour:
- Request: req = data_read_in | data_write_in. If both are high, the write wins; this combination is illegal upstream, and a bench assertion flags it.
- FSM states:
  - IDLE: bus_cyc_out=0. If req=1, go to BUSY and latch adr=address[31:2], we=data_write_in, sel=(we ? mask : 4'b1111), dat=write value; clear the timeout counter.
  - BUSY: bus_cyc_out=1; adr/we/sel/dat are driven from the latched registers and held stable. On bus_ack_in=1, go to DONE; for reads, latch bus_dat_in into rdata. Otherwise, when the counter equals TIMEOUT_CYCLES-1, go to DONE, set rdata=32'h0 and pulse bus_error_out for one cycle. Otherwise, increment the counter.
  - DONE: bus_cyc_out=0. Unconditionally return to IDLE next cycle.
- stall_out (combinational):
  - IDLE: stall_out = req.
  - BUSY: stall_out = 1.
  - DONE: stall_out = 0.
- The memory stage consumes the result at the edge that leaves DONE.
- Latency:
  - Minimum 2 stall cycles: IDLE→BUSY, then ack in the first BUSY cycle.
  - In general, an ack in the k-th BUSY cycle gives k+1 stall cycles.
  - A request made on the cycle after DONE starts a new transaction; there is no back-to-back bypass.
- data_read_value_out = rdata register at all times. It holds its value until the next read completes; writes do not modify it.
- Flush is not an input. Once a transaction has entered BUSY it always completes (ack or timeout). The hazard unit squashes the result.
- bus_ack_in outside BUSY is ignored.
- Counter width: $clog2(TIMEOUT_CYCLES+1). The counter does not wrap, because it exits at TIMEOUT_CYCLES-1.
- Reset (synchronous): state=IDLE, counter=0, rdata=0. Latched adr/sel/dat are reset to 0 and we=0. bus_cyc_out=0, bus_error_out=0.
- Reset asserted mid-BUSY drops bus_cyc_out on the next edge with no ack required. The bus slave must tolerate an abandoned cycle.

Decomposition:
- Package rv32_bus_pkg holds:
  - enum bus_state_t {IDLE, BUSY, DONE};
  - constant RV32_BUS_SEL_WORD = 4'b1111;
  - shared bus width constants (ADR 30, DAT 32, SEL 4).
- No sub-module. The counter and FSM are inline; the target is roughly 150 lines of RTL.

Test Plan:
- Read, ack in first BUSY cycle: data_read_in=1, address 32'h0000_1008, slave returns 32'hDEAD_BEEF → bus_adr_out=30'h402, bus_sel_out=4'b1111, bus_we_out=0; stall_out high for exactly 2 cycles; data_read_value_out=32'hDEAD_BEEF in DONE.
- Byte write with 3 wait states: write, mask 4'b0100, address 32'h0000_0006, data 32'h00AB_0000 → bus_sel_out=4'b0100, bus_dat_out=32'h00AB_0000, held stable for 4 BUSY cycles; stall_out high for 5 cycles; rdata unchanged.
- Timeout with TIMEOUT_CYCLES=4: read, no ack → bus_cyc_out high for exactly 4 cycles; bus_error_out pulses once; data_read_value_out=0; FSM returns to IDLE.
- Back-to-back reads: two consecutive read requests → two distinct cyc assertions separated by a DONE and an IDLE cycle; second result correct.
- Reset mid-BUSY: assert reset in the 2nd BUSY cycle → bus_cyc_out=0 and stall_out=0 on the following cycle (with req=0); a subsequent read completes normally.
- Spurious ack: bus_ack_in=1 while IDLE with no request → no state change, stall_out=0, rdata unchanged.
